// File: rtl/mem_arbiter_if.sv
// Purpose : bundles the I-cache, D-cache and main-memory handshake signals of mem_arbiter.
// Latency : none (signal container only).
// Backpressure : memory stalls via mem_ready; caches hold req until their done pulse.
// Ports (slave = arbiter view):
//   ic_req/ic_addr -> ic_done/ic_rdata        I-cache read channel
//   dc_req/dc_we/dc_addr/dc_wdata -> dc_done/dc_rdata   D-cache read/write channel
//   mem_req/mem_we/mem_addr/mem_wdata <- mem_ready/mem_rdata   main-memory port
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic                  ic_req;
  logic [ADDR_WIDTH-1:0] ic_addr;
  logic                  ic_done;
  logic [DATA_WIDTH-1:0] ic_rdata;

  logic                  dc_req;
  logic                  dc_we;
  logic [ADDR_WIDTH-1:0] dc_addr;
  logic [DATA_WIDTH-1:0] dc_wdata;
  logic                  dc_done;
  logic [DATA_WIDTH-1:0] dc_rdata;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ready;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Arbiter side.
  modport slave (
    input  ic_req, ic_addr,
    input  dc_req, dc_we, dc_addr, dc_wdata,
    input  mem_ready, mem_rdata,
    output ic_done, ic_rdata,
    output dc_done, dc_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  // Environment side: the two caches plus main memory.
  modport master (
    output ic_req, ic_addr,
    output dc_req, dc_we, dc_addr, dc_wdata,
    output mem_ready, mem_rdata,
    input  ic_done, ic_rdata,
    input  dc_done, dc_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Purpose : round-robin arbiter sharing one main-memory port between I-cache and D-cache.
// Latency : request in IDLE cycle N -> mem_req in N+1 -> done in N+2 at the earliest (+1 per mem_ready wait cycle).
// Backpressure : one transaction in flight; ACCESS holds until mem_ready, losing requester waits for the next IDLE.
// Ports:
//   i_clock  rising-edge clock
//   i_reset  synchronous active-low reset
//   bus      mem_arbiter_if.slave: cache request/response channels and memory port
module mem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic          i_clock,
  input  logic          i_reset,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_last_d;   // 1: most recent grant went to the D-cache
  logic                  r_own_d;    // owner of the in-flight transaction
  logic                  r_ic_done;
  logic                  r_dc_done;
  logic [DATA_WIDTH-1:0] r_ic_rdata;
  logic [DATA_WIDTH-1:0] r_dc_rdata;
  logic                  r_mem_req;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;

  // D wins when it is the only requester, or on a tie when I was served last.
  // After reset r_last_d=0 (last grant = I), so the first tie goes to D.
  logic w_grant_d;
  logic w_grant_any;
  assign w_grant_d   = bus.dc_req & (~bus.ic_req | ~r_last_d);
  assign w_grant_any = bus.dc_req | bus.ic_req;

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state     <= S_IDLE;
      r_last_d    <= 1'b0;
      r_own_d     <= 1'b0;
      r_ic_done   <= 1'b0;
      r_dc_done   <= 1'b0;
      r_ic_rdata  <= '0;
      r_dc_rdata  <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ic_done <= 1'b0;
          r_dc_done <= 1'b0;
          if (w_grant_any) begin
            // The mem_* registers double as the latched request; they are
            // only cleared once the memory has accepted it.
            r_own_d   <= w_grant_d;
            r_last_d  <= w_grant_d;
            r_mem_req <= 1'b1;
            if (w_grant_d) begin
              r_mem_we    <= bus.dc_we;
              r_mem_addr  <= bus.dc_addr;
              r_mem_wdata <= bus.dc_wdata;
            end else begin
              r_mem_we    <= 1'b0;
              r_mem_addr  <= bus.ic_addr;
              r_mem_wdata <= '0;
            end
            r_state <= S_ACCESS;
          end
        end

        S_ACCESS: begin
          if (bus.mem_ready) begin
            // Read data is routed only to the owner, and only for reads, so
            // D writes never disturb dc_rdata and ic_rdata tracks I traffic only.
            if (!r_mem_we) begin
              if (r_own_d) r_dc_rdata <= bus.mem_rdata;
              else         r_ic_rdata <= bus.mem_rdata;
            end
            r_ic_done   <= ~r_own_d;
            r_dc_done   <= r_own_d;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_state     <= S_RESP;
          end
        end

        S_RESP: begin
          r_ic_done <= 1'b0;
          r_dc_done <= 1'b0;
          r_state   <= S_IDLE;
        end

        default: begin
          r_ic_done <= 1'b0;
          r_dc_done <= 1'b0;
          r_mem_req <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ic_done   = r_ic_done;
  assign bus.ic_rdata  = r_ic_rdata;
  assign bus.dc_done   = r_dc_done;
  assign bus.dc_rdata  = r_dc_rdata;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose : self-checking bench for mem_arbiter; expected transactions queued on stimulus, popped on done.
// Latency : fixed cycle-by-cycle stepping, outputs sampled 1 time unit after each rising edge.
// Backpressure : memory wait states modelled by holding mem_ready low for a chosen number of cycles.
module tb_mem_arbiter;
  localparam int AW = 16;
  localparam int DW = 32;

  typedef struct {
    logic          is_d;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } txn_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  txn_t          sb[$];
  txn_t          t;
  int            n_checks = 0;
  int            n_pass   = 0;
  logic [DW-1:0] exp_ic_rdata = '0;
  logic [DW-1:0] exp_dc_rdata = '0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.ic_req = 1'b1; bus.ic_addr = 16'h0040;
    bus.dc_req = 1'b1; bus.dc_we = 1'b0; bus.dc_addr = 16'h0200; bus.dc_wdata = 32'h5555_AAAA;
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'hCAFE_0001;
    rst_n = 1'b0;
    step(); step();
    exp_ic_rdata = '0; exp_dc_rdata = '0;
    n_checks++;
    if ({bus.mem_req, bus.mem_we, bus.ic_done, bus.dc_done} !== 4'b0000)
      $display("FAIL reset_ctrl: got req/we/icd/dcd=%b want 0000",
               {bus.mem_req, bus.mem_we, bus.ic_done, bus.dc_done});
    else n_pass++;
    n_checks++;
    if ({bus.mem_addr, bus.mem_wdata, bus.ic_rdata, bus.dc_rdata} !== '0)
      $display("FAIL reset_data: addr=%h wdata=%h ic_rdata=%h dc_rdata=%h want all 0",
               bus.mem_addr, bus.mem_wdata, bus.ic_rdata, bus.dc_rdata);
    else n_pass++;
    // Release with both requests pending: first tie must go to D.
    sb.push_back('{is_d: 1'b1, we: 1'b0, addr: 16'h0200, wdata: 32'h0, rdata: 32'hCAFE_0001});
    rst_n = 1'b1;
    step();
    n_checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== sb[0].addr)
      $display("FAIL reset_first_grant: mem_req=%b mem_addr=%h want 1/%h", bus.mem_req, bus.mem_addr, sb[0].addr);
    else n_pass++;
    step();
    t = sb.pop_front();
    exp_dc_rdata = t.rdata;
    n_checks++;
    if (bus.dc_done !== 1'b1 || bus.ic_done !== 1'b0 || bus.dc_rdata !== exp_dc_rdata)
      $display("FAIL reset_first_done: dcd=%b icd=%b dc_rdata=%h want 1/0/%h",
               bus.dc_done, bus.ic_done, bus.dc_rdata, exp_dc_rdata);
    else n_pass++;
    bus.ic_req = 1'b0; bus.dc_req = 1'b0; bus.mem_ready = 1'b0;
    step();
  endtask

  task automatic test_single_i();
    sb.push_back('{is_d: 1'b0, we: 1'b0, addr: 16'h0040, wdata: 32'h0, rdata: 32'hDEAD_BEEF});
    bus.ic_req = 1'b1; bus.ic_addr = 16'h0040;
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
    step();
    n_checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== sb[0].addr || bus.mem_we !== 1'b0 || bus.dc_done !== 1'b0)
      $display("FAIL single_i_access: req=%b addr=%h we=%b dcd=%b want 1/%h/0/0",
               bus.mem_req, bus.mem_addr, bus.mem_we, bus.dc_done, sb[0].addr);
    else n_pass++;
    step();
    t = sb.pop_front();
    exp_ic_rdata = t.rdata;
    n_checks++;
    if (bus.ic_done !== 1'b1 || bus.ic_rdata !== exp_ic_rdata || bus.dc_done !== 1'b0 || bus.mem_req !== 1'b0)
      $display("FAIL single_i_done: icd=%b ic_rdata=%h dcd=%b req=%b want 1/%h/0/0",
               bus.ic_done, bus.ic_rdata, bus.dc_done, bus.mem_req, exp_ic_rdata);
    else n_pass++;
    n_checks++;
    if (bus.dc_rdata !== exp_dc_rdata)
      $display("FAIL single_i_isolation: dc_rdata=%h want %h", bus.dc_rdata, exp_dc_rdata);
    else n_pass++;
    bus.ic_req = 1'b0; bus.mem_ready = 1'b0;
    step();
    n_checks++;
    if (bus.ic_done !== 1'b0)
      $display("FAIL single_i_pulse: ic_done=%b want 0", bus.ic_done);
    else n_pass++;
  endtask

  task automatic test_d_write_wait();
    sb.push_back('{is_d: 1'b1, we: 1'b1, addr: 16'h0100, wdata: 32'h1234_5678, rdata: 32'h0});
    bus.dc_req = 1'b1; bus.dc_we = 1'b1; bus.dc_addr = 16'h0100; bus.dc_wdata = 32'h1234_5678;
    bus.mem_ready = 1'b0; bus.mem_rdata = 32'hBAD0_BAD0;
    step();
    for (int k = 0; k < 4; k++) begin
      if (k == 3) bus.mem_ready = 1'b1;   // memory accepts in the 4th ACCESS cycle
      // Non-granted side toggling must have no effect.
      bus.ic_addr = 16'h0F00 + 16'(k);
      n_checks++;
      if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== sb[0].addr ||
          bus.mem_wdata !== sb[0].wdata || bus.dc_done !== 1'b0)
        $display("FAIL d_write_hold[%0d]: req=%b we=%b addr=%h wdata=%h dcd=%b want 1/1/%h/%h/0",
                 k, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.dc_done,
                 sb[0].addr, sb[0].wdata);
      else n_pass++;
      step();
    end
    t = sb.pop_front();
    n_checks++;
    if (bus.dc_done !== 1'b1 || bus.dc_rdata !== exp_dc_rdata || bus.ic_rdata !== exp_ic_rdata ||
        bus.mem_req !== 1'b0 || bus.mem_wdata !== '0)
      $display("FAIL d_write_done: dcd=%b dc_rdata=%h ic_rdata=%h req=%b wdata=%h want 1/%h/%h/0/0",
               bus.dc_done, bus.dc_rdata, bus.ic_rdata, bus.mem_req, bus.mem_wdata,
               exp_dc_rdata, exp_ic_rdata);
    else n_pass++;
    bus.dc_req = 1'b0; bus.dc_we = 1'b0; bus.mem_ready = 1'b0;
    step();
    n_checks++;
    if (bus.dc_done !== 1'b0)
      $display("FAIL d_write_pulse: dc_done=%b want 0", bus.dc_done);
    else n_pass++;
  endtask

  task automatic test_alternate();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    exp_ic_rdata = '0; exp_dc_rdata = '0;
    bus.ic_req = 1'b1; bus.ic_addr = 16'h00A0;
    bus.dc_req = 1'b1; bus.dc_we = 1'b0; bus.dc_addr = 16'h00D0; bus.dc_wdata = 32'h0;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      // Round robin from reset: D, I, D, I.
      t.is_d = (i % 2 == 0);
      t.we = 1'b0;
      t.addr = t.is_d ? 16'h00D0 : 16'h00A0;
      t.wdata = '0;
      t.rdata = 32'hA000_0000 + 32'(i);
      sb.push_back(t);
      bus.mem_rdata = t.rdata;
      step();
      n_checks++;
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== sb[0].addr)
        $display("FAIL alt_grant[%0d]: req=%b addr=%h want 1/%h", i, bus.mem_req, bus.mem_addr, sb[0].addr);
      else n_pass++;
      step();
      t = sb.pop_front();
      if (t.is_d) exp_dc_rdata = t.rdata; else exp_ic_rdata = t.rdata;
      n_checks++;
      if (bus.dc_done !== t.is_d || bus.ic_done !== !t.is_d ||
          bus.ic_rdata !== exp_ic_rdata || bus.dc_rdata !== exp_dc_rdata)
        $display("FAIL alt_done[%0d]: dcd=%b icd=%b ic_rdata=%h dc_rdata=%h want %b/%b/%h/%h",
                 i, bus.dc_done, bus.ic_done, bus.ic_rdata, bus.dc_rdata,
                 t.is_d, !t.is_d, exp_ic_rdata, exp_dc_rdata);
      else n_pass++;
      step();
      if (i == 3) begin
        bus.ic_req = 1'b0; bus.dc_req = 1'b0;
      end
      n_checks++;
      if (bus.ic_done !== 1'b0 || bus.dc_done !== 1'b0 || bus.mem_req !== 1'b0)
        $display("FAIL alt_idle[%0d]: icd=%b dcd=%b req=%b want 0/0/0", i, bus.ic_done, bus.dc_done, bus.mem_req);
      else n_pass++;
    end
    bus.mem_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus.dc_req = 1'b1; bus.dc_we = 1'b0; bus.dc_addr = 16'h0300;
    bus.mem_ready = 1'b0; bus.mem_rdata = 32'h7777_7777;
    step();
    n_checks++;
    if (bus.mem_req !== 1'b1)
      $display("FAIL reset_mid_access: mem_req=%b want 1", bus.mem_req);
    else n_pass++;
    rst_n = 1'b0;
    step();
    exp_ic_rdata = '0; exp_dc_rdata = '0;
    n_checks++;
    if (bus.mem_req !== 1'b0 || bus.dc_done !== 1'b0 || bus.dc_rdata !== exp_dc_rdata)
      $display("FAIL reset_mid_abort: req=%b dcd=%b dc_rdata=%h want 0/0/%h",
               bus.mem_req, bus.dc_done, bus.dc_rdata, exp_dc_rdata);
    else n_pass++;
    rst_n = 1'b1; bus.dc_req = 1'b0;
    step();
    n_checks++;
    if (bus.mem_req !== 1'b0 || bus.dc_done !== 1'b0)
      $display("FAIL reset_mid_quiet: req=%b dcd=%b want 0/0", bus.mem_req, bus.dc_done);
    else n_pass++;
    // FSM back in IDLE: a fresh I read gets minimum latency.
    sb.push_back('{is_d: 1'b0, we: 1'b0, addr: 16'h0044, wdata: 32'h0, rdata: 32'h0BAD_F00D});
    bus.ic_req = 1'b1; bus.ic_addr = 16'h0044; bus.mem_ready = 1'b1; bus.mem_rdata = 32'h0BAD_F00D;
    step();
    n_checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== sb[0].addr)
      $display("FAIL reset_mid_regrant: req=%b addr=%h want 1/%h", bus.mem_req, bus.mem_addr, sb[0].addr);
    else n_pass++;
    step();
    t = sb.pop_front();
    exp_ic_rdata = t.rdata;
    n_checks++;
    if (bus.ic_done !== 1'b1 || bus.ic_rdata !== exp_ic_rdata)
      $display("FAIL reset_mid_done: icd=%b ic_rdata=%h want 1/%h", bus.ic_done, bus.ic_rdata, exp_ic_rdata);
    else n_pass++;
    bus.ic_req = 1'b0; bus.mem_ready = 1'b0;
    step();
  endtask

  task automatic test_late_ready();
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
    step(); step();
    n_checks++;
    if (bus.mem_req !== 1'b0 || bus.ic_done !== 1'b0 || bus.dc_done !== 1'b0 ||
        bus.ic_rdata !== exp_ic_rdata || bus.dc_rdata !== exp_dc_rdata)
      $display("FAIL late_ready: req=%b icd=%b dcd=%b ic_rdata=%h dc_rdata=%h want 0/0/0/%h/%h",
               bus.mem_req, bus.ic_done, bus.dc_done, bus.ic_rdata, bus.dc_rdata,
               exp_ic_rdata, exp_dc_rdata);
    else n_pass++;
    bus.mem_ready = 1'b0;
    step();
  endtask

  initial begin
    bus.ic_req = 1'b0; bus.ic_addr = '0;
    bus.dc_req = 1'b0; bus.dc_we = 1'b0; bus.dc_addr = '0; bus.dc_wdata = '0;
    bus.mem_ready = 1'b0; bus.mem_rdata = '0;
    test_reset();
    test_single_i();
    test_d_write_wait();
    test_alternate();
    test_reset_mid();
    test_late_ready();
    n_checks++;
    if (sb.size() != 0)
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end
endmodule
